data_mem_lsu: RTL
=================

Name: data_mem_lsu

Overview:
Load/store initiator that drives the core's single-port-style word data memory (32-bit words, byte-addressed, 1-cycle registered read, write-enable with no byte enables).
- Accepts RV32I load/store requests from the execute stage.
- Extracts and sign/zero-extends sub-word loads.
- Performs read-modify-write for SB/SH, since the memory only writes whole words.
- Flags misaligned, illegal and out-of-range accesses.

Parameters:
ADDR_SIZE, 7, top byte-address bit decoded by the data memory; valid byte addresses are 0 .. 2**(ADDR_SIZE+1)-1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted on a clk edge where req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, value in low bits
resp_valid  out  1  single-cycle completion pulse, no back-pressure
resp_data  out  32  load result (0 for stores and errors)
resp_error  out  1  access faulted; qualified by resp_valid
mem_read_addr  out  32  to memory read_addr
mem_read_data  in  32  from memory read_data (valid 1 cycle after address sampled)
mem_write_addr  out  32  to memory write_addr
mem_write_data  out  32  to memory write_data
mem_write_enable  out  1  to memory write_enable

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, LOAD, MERGE, WRITE. req_ready = (state == IDLE), combinational from state only.
- mem_read_addr = {req_addr[31:2], 2'b00} while IDLE; otherwise it holds the captured word address.
- All other outputs are registered.
- Reset values: state IDLE; resp_valid 0, resp_error 0, resp_data 0; mem_write_enable 0; mem_write_addr 0, mem_write_data 0.
- Error check at accept; first match wins:
  - funct3 illegal: load 3/6/7, or store >= 3.
  - Address out of range: req_addr[31:ADDR_SIZE+1] != 0.
  - Misaligned: H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0.
- Error response:
  - Next cycle: resp_valid = 1, resp_error = 1, resp_data = 0.
  - State stays IDLE. No memory write ever occurs.
- Load (edge E0 accept):
  - IDLE→LOAD; mem_read_data is valid during LOAD.
  - At E1: resp_data = byte/half selected by captured addr[1:0], extended (B/H sign, BU/HU zero; W whole word). resp_valid = 1. State → IDLE.
  - Latency 2; a new request can be accepted in the resp_valid cycle.
- SW (E0 accept):
  - At E0: mem_write_addr = word address, mem_write_data = req_wdata, mem_write_enable = 1, resp_valid = 1, state → WRITE.
  - At E1: write commits; enable → 0, state → IDLE.
- SB/SH (E0 accept):
  - At E0: read issued, state → MERGE.
  - At E1: mem_write_data = mem_read_data with byte/half lane addr[1:0] replaced by req_wdata[7:0] / [15:0]. mem_write_enable = 1, resp_valid = 1, state → WRITE.
  - At E2: commit, state → IDLE.
- Little-endian lane mapping: byte k = bits [8k+7:8k].
- req_ready is low during LOAD, MERGE and WRITE. A read is therefore never sampled on the same edge as a write commit, which avoids read-during-write old-data hazards.
- Request fields are sampled only at accept; they are don't-care otherwise.
- resp_valid is high for exactly one cycle per accepted request, except when the transaction is aborted by reset.
- Reset mid-operation:
  - Next edge: IDLE, mem_write_enable 0, no resp_valid; the transaction is dropped.
  - Reset in MERGE: no write occurs.
  - Reset in WRITE: the write commits on the same edge as reset, because memory samples the enable high at that edge.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses produce an error response as above.
- Undefined:
  - Misalignment is not checked; the address is aligned down (H: clear bit 0; W: clear bits 1:0) and the access proceeds normally.
  - resp_error is asserted only for illegal funct3 and out-of-range addresses.

Test Plan:
- SW 0x20 data 0xA1B2C3D4 → mem_write_enable high exactly 1 cycle with addr 0x20; then LW 0x20 → resp_valid 2 cycles after accept, resp_data 0xA1B2C3D4, resp_error 0.
- LB 0x23 → 0xFFFFFFA1; LBU 0x23 → 0x000000A1; LH 0x22 → 0xFFFFA1B2; LHU 0x20 → 0x0000C3D4.
- SB 0x21 data 0x000000EE → word 0xA1B2EED4; then SH 0x22 data 0x00005566 → LW 0x20 returns 0x5566EED4. req_ready low for 2 cycles after each sub-word store accept.
- With LSU_MISALIGN_TRAP_EN: LW 0x22 → resp_error 1, resp_data 0, no write. Without it: LW 0x22 returns word at 0x20. Out-of-range LW 0x100 (ADDR_SIZE 7) and funct3 = 3 → resp_error 1 in both builds.
- Back-to-back: LW accepted in the same cycle as the previous load's resp_valid → consecutive correct responses. SW followed immediately by LW to the same address → LW accepted only after WRITE and returns the new data.
- rst pulsed during MERGE of SB 0x24 → no mem_write_enable, resp_valid stays 0, word at 0x24 unchanged, req_ready = 1 the cycle after reset.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
`timescale 1ns/1ps

interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/data_mem_lsu.sv
// RV32I load/store unit driving a whole-word data memory with a 1-cycle read.
// Sub-word stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
`timescale 1ns/1ps

module data_mem_lsu #(
    parameter int ADDR_SIZE = 7
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_lsu_if.slave bus,
    output logic [31:0]   mem_read_addr,
    input  logic [31:0]   mem_read_data,
    output logic [31:0]   mem_write_addr,
    output logic [31:0]   mem_write_data,
    output logic          mem_write_enable
);

    typedef enum logic [1:0] {IDLE, LOAD, MERGE, WRITE} state_t;

    state_t      state;
    logic [29:0] cap_word;
    logic [1:0]  cap_lane;
    logic [2:0]  cap_funct3;
    logic [15:0] cap_wdata;

    logic        is_illegal;
    logic        is_out_of_range;
    logic        req_error;
    logic [1:0]  req_lane;

    assign bus.req_ready = (state == IDLE);
    assign mem_read_addr = (state == IDLE) ? {bus.req_addr[31:2], 2'b00} : {cap_word, 2'b00};

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        is_illegal      = 1'b0;
        is_out_of_range = |bus.req_addr[31:ADDR_SIZE+1];
        req_lane        = bus.req_addr[1:0];
        if (bus.req_we)
            is_illegal = (bus.req_funct3 >= 3'd3);
        else
            is_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                         (bus.req_funct3 == 3'd7);
        // Halves and words are aligned down; only matters when misalignment does not trap.
        case (bus.req_funct3[1:0])
            2'b01:   req_lane = {bus.req_addr[1], 1'b0};
            2'b10:   req_lane = 2'b00;
            default: req_lane = bus.req_addr[1:0];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_error = is_illegal || is_out_of_range ||
                    ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        req_error = is_illegal || is_out_of_range;
`endif
    end

    // Little-endian lane select plus sign/zero extension; funct3[2] marks unsigned.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [2:0] funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3[1:0])
            2'b00:   return {{24{b[7] & ~funct3[2]}}, b};
            2'b01:   return {{16{h[15] & ~funct3[2]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] funct3, input logic [15:0] wdata);
        logic [31:0] merged;
        merged = word;
        if (funct3[1:0] == 2'b00)
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            merged[{lane[1], 4'b0000} +: 16] = wdata;
        return merged;
    endfunction

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: capture registers are left unreset; they are only read after a fresh accept.
            state            <= IDLE;
            bus.resp_valid   <= 1'b0;
            bus.resp_error   <= 1'b0;
            bus.resp_data    <= '0;
            mem_write_enable <= 1'b0;
            mem_write_addr   <= '0;
            mem_write_data   <= '0;
        end else begin
            bus.resp_valid   <= 1'b0;
            bus.resp_error   <= 1'b0;
            bus.resp_data    <= '0;
            mem_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_word   <= bus.req_addr[31:2];
                        cap_lane   <= req_lane;
                        cap_funct3 <= bus.req_funct3;
                        cap_wdata  <= bus.req_wdata[15:0];
                        if (req_error) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                        end else if (!bus.req_we) begin
                            state <= LOAD;
                        end else if (bus.req_funct3 == 3'd2) begin
                            mem_write_addr   <= {bus.req_addr[31:2], 2'b00};
                            mem_write_data   <= bus.req_wdata;
                            mem_write_enable <= 1'b1;
                            bus.resp_valid   <= 1'b1;
                            state            <= WRITE;
                        end else begin
                            state <= MERGE;
                        end
                    end
                end
                LOAD: begin
                    bus.resp_data  <= load_extract(mem_read_data, cap_lane, cap_funct3);
                    bus.resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                MERGE: begin
                    mem_write_addr   <= {cap_word, 2'b00};
                    mem_write_data   <= store_merge(mem_read_data, cap_lane, cap_funct3, cap_wdata);
                    mem_write_enable <= 1'b1;
                    bus.resp_valid   <= 1'b1;
                    state            <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
